// File: rtl/ahb_burst_pkg.sv
// Shared definitions for the AHB burst address sequencer: bus encodings,
// FSM state type, burst context payload and address-prediction helpers.
package ahb_burst_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned CNT_W        = 5;
    localparam int unsigned MAX_BEATS    = 16;
    localparam int unsigned BOUNDARY_LSB = 10;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_BUSY  = 2'd2
    } state_e;

    // Attributes of the open burst, captured on its NONSEQ beat.
    typedef struct packed {
        logic [CNT_W-1:0] len;    // 0 means unbounded INCR
        logic [2:0]       size;
        logic             wrap;
        logic             fixed;  // fixed-length multi-beat burst
        logic             unb;    // unbounded INCR
    } burst_ctx_t;

    // Beat count of a burst type; unbounded INCR returns 0.
    function automatic logic [CNT_W-1:0] burst_len(input logic [2:0] hburst);
        logic [CNT_W-1:0] len;
        case (hburst)
            HBURST_SINGLE:                len = CNT_W'(1);
            HBURST_INCR:                  len = CNT_W'(0);
            HBURST_WRAP4,  HBURST_INCR4:  len = CNT_W'(4);
            HBURST_WRAP8,  HBURST_INCR8:  len = CNT_W'(8);
            HBURST_WRAP16, HBURST_INCR16: len = CNT_W'(16);
            default:                      len = CNT_W'(0);
        endcase
        return len;
    endfunction

    // Address of the beat following addr, for incrementing or wrapping bursts.
    function automatic logic [ADDR_W-1:0] next_addr_calc(
        input logic [ADDR_W-1:0] addr,
        input logic [2:0]        size,
        input logic [CNT_W-1:0]  len,
        input logic              wrap
    );
        logic [ADDR_W-1:0] bytes;
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] incr;
        bytes = ADDR_W'(1) << size;
        mask  = (ADDR_W'(len) * bytes) - ADDR_W'(1);
        incr  = addr + bytes;
        if (wrap) begin
            return (addr & ~mask) | (incr & mask);
        end
        return incr;
    endfunction

endpackage

// File: rtl/ahb_burst_len_dec.sv
// Decodes HBURST into a one-hot burst type, beat length and wrap flag.
module ahb_burst_len_dec
    import ahb_burst_pkg::*;
(
    input  logic [2:0]       hburst_i,
    output logic [7:0]       type_oh_o,
    output logic [CNT_W-1:0] len_o,
    output logic             wrap_o
);

    // One-hot indexed by the raw HBURST encoding.
    assign type_oh_o = 8'(1) << hburst_i;

    // Beat length from the shared table.
    assign len_o = burst_len(hburst_i);

    // Wrapping types are the even encodings above SINGLE.
    assign wrap_o = (hburst_i == HBURST_WRAP4) ||
                    (hburst_i == HBURST_WRAP8) ||
                    (hburst_i == HBURST_WRAP16);

endmodule

// File: rtl/ahb_burst_addr_seq.sv
// AHB burst address sequencer: tracks bursts on the address phase, predicts
// the next beat address, counts beats and flags completion, early
// termination and sequence errors. All outputs are registered.
// Optional: define AHB_1KB_BOUNDARY_CHECK_EN to flag incrementing bursts
// whose predicted address leaves the current 1KB region.
module ahb_burst_addr_seq
    import ahb_burst_pkg::*;
(
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [1:0]        HTRANS,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic              HREADY,
    output logic [ADDR_W-1:0] NEXT_ADDR,
    output logic [CNT_W-1:0]  BEAT_CNT,
    output logic              BURST_ACTIVE,
    output logic              BURST_LAST,
    output logic              EARLY_TERM,
    output logic              SEQ_ERR
);

    state_e            state_q, state_d;
    burst_ctx_t        ctx_q, ctx_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              active_q, active_d;
    logic              last_q, last_d;
    logic              early_q, early_d;
    logic              err_q, err_d;

    logic [7:0]        dec_oh;
    logic [CNT_W-1:0]  dec_len;
    logic              dec_wrap;
    logic [ADDR_W-1:0] nonseq_next;
    logic [ADDR_W-1:0] beat_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic              in_burst;

    ahb_burst_len_dec u_len_dec (
        .hburst_i  (HBURST),
        .type_oh_o (dec_oh),
        .len_o     (dec_len),
        .wrap_o    (dec_wrap)
    );

    // Prediction for a fresh burst and for continuing the open one.
    assign nonseq_next = next_addr_calc(HADDR, HSIZE, dec_len, dec_wrap);
    assign beat_next   = next_addr_calc(next_addr_q, ctx_q.size, ctx_q.len, ctx_q.wrap);
    assign cnt_inc     = beat_cnt_q + CNT_W'(1);
    assign in_burst    = (state_q != S_IDLE);

    // Next-state and output decode; HREADY low holds everything but pulses.
    always_comb begin
        state_d     = state_q;
        ctx_d       = ctx_q;
        next_addr_d = next_addr_q;
        beat_cnt_d  = beat_cnt_q;
        active_d    = active_q;
        last_d      = 1'b0;
        early_d     = 1'b0;
        err_d       = 1'b0;

        if (HREADY) begin
            case (HTRANS)
                HTRANS_NONSEQ: begin
                    early_d     = in_burst && ctx_q.fixed;
                    ctx_d.len   = dec_len;
                    ctx_d.size  = HSIZE;
                    ctx_d.wrap  = dec_wrap;
                    ctx_d.fixed = |dec_oh[7:2];
                    ctx_d.unb   = dec_oh[1];
                    beat_cnt_d  = CNT_W'(1);
                    next_addr_d = nonseq_next;
                    if (dec_oh[0]) begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                        last_d   = 1'b1;
                    end else begin
                        state_d  = S_BURST;
                        active_d = 1'b1;
                    end
`ifdef AHB_1KB_BOUNDARY_CHECK_EN
                    if (!dec_wrap && !dec_oh[0] &&
                        (nonseq_next[ADDR_W-1:BOUNDARY_LSB] != HADDR[ADDR_W-1:BOUNDARY_LSB])) begin
                        err_d = 1'b1;
                    end
`endif
                end
                HTRANS_SEQ: begin
                    if (!in_burst) begin
                        err_d = 1'b1;
                    end else begin
                        err_d       = (HADDR != next_addr_q);
                        state_d     = S_BURST;
                        next_addr_d = beat_next;
                        if (ctx_q.unb && (beat_cnt_q == CNT_W'(MAX_BEATS))) begin
                            beat_cnt_d = beat_cnt_q;
                        end else begin
                            beat_cnt_d = cnt_inc;
                        end
                        if (ctx_q.fixed && (cnt_inc == ctx_q.len)) begin
                            state_d  = S_IDLE;
                            active_d = 1'b0;
                            last_d   = 1'b1;
                        end
`ifdef AHB_1KB_BOUNDARY_CHECK_EN
                        if (!ctx_q.wrap &&
                            (beat_next[ADDR_W-1:BOUNDARY_LSB] != next_addr_q[ADDR_W-1:BOUNDARY_LSB])) begin
                            err_d = 1'b1;
                        end
`endif
                    end
                end
                HTRANS_BUSY: begin
                    if (state_q == S_BURST) begin
                        state_d = S_BUSY;
                    end
                end
                default: begin
                    if (in_burst) begin
                        early_d  = ctx_q.fixed;
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            ctx_q       <= '0;
            next_addr_q <= '0;
            beat_cnt_q  <= '0;
            active_q    <= 1'b0;
            last_q      <= 1'b0;
            early_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctx_q       <= ctx_d;
            next_addr_q <= next_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            active_q    <= active_d;
            last_q      <= last_d;
            early_q     <= early_d;
            err_q       <= err_d;
        end
    end

    assign NEXT_ADDR    = next_addr_q;
    assign BEAT_CNT     = beat_cnt_q;
    assign BURST_ACTIVE = active_q;
    assign BURST_LAST   = last_q;
    assign EARLY_TERM   = early_q;
    assign SEQ_ERR      = err_q;

endmodule

// File: tb/tb_ahb_burst_addr_seq.sv
// Self-checking bench for ahb_burst_addr_seq: directed scenarios with literal
// expectations plus randomized bursts checked against a behavioural model.
module tb_ahb_burst_addr_seq;

    logic        HCLK;
    logic        HRESETn;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HREADY;
    logic [31:0] NEXT_ADDR;
    logic [4:0]  BEAT_CNT;
    logic        BURST_ACTIVE;
    logic        BURST_LAST;
    logic        EARLY_TERM;
    logic        SEQ_ERR;

    int checks = 0;
    int errors = 0;

    // Expected outputs and burst view held by the model.
    logic [31:0] e_next;
    logic [4:0]  e_cnt;
    logic        e_active, e_last, e_early, e_err;
    bit          m_open;
    int          m_len;
    bit          m_wrap;
    longint      m_bytes;

    ahb_burst_addr_seq dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HTRANS       (HTRANS),
        .HADDR        (HADDR),
        .HSIZE        (HSIZE),
        .HBURST       (HBURST),
        .HREADY       (HREADY),
        .NEXT_ADDR    (NEXT_ADDR),
        .BEAT_CNT     (BEAT_CNT),
        .BURST_ACTIVE (BURST_ACTIVE),
        .BURST_LAST   (BURST_LAST),
        .EARLY_TERM   (EARLY_TERM),
        .SEQ_ERR      (SEQ_ERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int len_of(input logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd1:       return 0;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    function automatic bit wrap_of(input logic [2:0] b);
        return (b == 3'd2) || (b == 3'd4) || (b == 3'd6);
    endfunction

    // Next beat address: plain increment, or stay inside the aligned wrap window.
    function automatic logic [31:0] predict(input logic [31:0] addr, input longint bytes,
                                            input int len, input bit wrap);
        longint a, span, off;
        a = longint'(addr);
        if (!wrap) return 32'(a + bytes);
        span = longint'(len) * bytes;
        off  = a % span;
        return 32'((a - off) + ((off + bytes) % span));
    endfunction

    task automatic model_reset();
        m_open = 0; m_len = 0; m_wrap = 0; m_bytes = 1;
        e_next = '0; e_cnt = '0; e_active = 0; e_last = 0; e_early = 0; e_err = 0;
    endtask

    // One accepted-or-stalled clock of the protocol, as seen from the bus.
    task automatic model_step(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                              input logic [2:0] b, input logic rdy);
        logic [31:0] cur;
        e_last = 0; e_early = 0; e_err = 0;
        if (!rdy) return;
        case (tr)
            2'b10: begin
                if (m_open && m_len != 0) e_early = 1;
                m_len   = len_of(b);
                m_wrap  = wrap_of(b);
                m_bytes = longint'(1) << sz;
                e_cnt   = 5'd1;
                e_next  = predict(a, m_bytes, m_len, m_wrap);
                m_open  = (m_len != 1);
                e_last  = (m_len == 1);
`ifdef AHB_1KB_BOUNDARY_CHECK_EN
                if (m_open && !m_wrap && (e_next[31:10] != a[31:10])) e_err = 1;
`endif
            end
            2'b11: begin
                if (!m_open) begin
                    e_err = 1;
                end else begin
                    cur = e_next;
                    e_err = (a != cur);
                    if (!(m_len == 0 && e_cnt == 5'd16)) e_cnt = e_cnt + 5'd1;
                    e_next = predict(cur, m_bytes, m_len, m_wrap);
                    if (m_len != 0 && int'(e_cnt) == m_len) begin
                        m_open = 0;
                        e_last = 1;
                    end
`ifdef AHB_1KB_BOUNDARY_CHECK_EN
                    if (!m_wrap && (e_next[31:10] != cur[31:10])) e_err = 1;
`endif
                end
            end
            2'b00: begin
                if (m_open) begin
                    if (m_len != 0) e_early = 1;
                    m_open = 0;
                end
            end
            default: ;
        endcase
        e_active = m_open;
    endtask

    // Drive one cycle's inputs, let the edge happen, advance the model.
    task automatic cycle(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [2:0] b, input logic rdy);
        HTRANS = tr; HADDR = a; HSIZE = sz; HBURST = b; HREADY = rdy;
        @(posedge HCLK);
        model_step(tr, a, sz, b, rdy);
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle, released two edges later.
    task automatic mid_reset(input bit check_now);
        #2;
        HRESETn = 1'b0;
        model_reset();
        #1;
        if (check_now) begin
            chk("rst_next", NEXT_ADDR, 32'h0);
            chk("rst_cnt", 32'(BEAT_CNT), 32'd0);
            chk("rst_flags", {28'd0, BURST_ACTIVE, BURST_LAST, EARLY_TERM, SEQ_ERR}, 32'd0);
        end
        HTRANS = 2'b00;
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge HCLK) begin
        chk("m_next_addr", NEXT_ADDR, e_next);
        chk("m_beat_cnt", 32'(BEAT_CNT), 32'(e_cnt));
        chk("m_active", 32'(BURST_ACTIVE), 32'(e_active));
        chk("m_last", 32'(BURST_LAST), 32'(e_last));
        chk("m_early", 32'(EARLY_TERM), 32'(e_early));
        chk("m_seq_err", 32'(SEQ_ERR), 32'(e_err));
    end

    task automatic random_burst();
        logic [2:0]  b;
        logic [2:0]  sz;
        logic [31:0] addr, a;
        longint      bytes;
        int          len, nbeats, stop, endk;
        bit          wr;
        b      = 3'($urandom_range(0, 7));
        sz     = 3'($urandom_range(0, 2));
        bytes  = longint'(1) << sz;
        len    = len_of(b);
        wr     = wrap_of(b);
        nbeats = (len == 0) ? int'($urandom_range(1, 20)) : len;
        stop   = nbeats;
        if (nbeats > 1 && $urandom_range(0, 5) == 0) stop = int'($urandom_range(1, nbeats - 1));
        addr   = $urandom & ~(32'(bytes) - 32'd1);
        for (int i = 0; i < stop; i++) begin
            while ($urandom_range(0, 3) == 0)
                cycle(2'($urandom_range(0, 3)), $urandom, sz, b, 1'b0);
            if (i > 0 && $urandom_range(0, 4) == 0)
                repeat ($urandom_range(1, 2)) cycle(2'b01, addr, sz, b, 1'b1);
            a = addr;
            if (i > 0 && $urandom_range(0, 15) == 0) a = addr ^ 32'h4;
            cycle((i == 0) ? 2'b10 : 2'b11, a, sz, b, 1'b1);
            addr = predict(addr, bytes, len, wr);
        end
        endk = int'($urandom_range(0, 9));
        if (endk < 5) repeat ($urandom_range(1, 3)) cycle(2'b00, $urandom, sz, b, 1'b1);
        else if (endk == 5) cycle(2'b11, $urandom, sz, b, 1'b1);
        else if (endk == 6) cycle(2'b01, $urandom, sz, b, 1'b1);
        if ($urandom_range(0, 39) == 0) mid_reset(1'b0);
    endtask

    initial begin
        HRESETn = 1'b0;
        HTRANS = 2'b00; HADDR = '0; HSIZE = '0; HBURST = '0; HREADY = 1'b1;
        model_reset();
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_next", NEXT_ADDR, 32'h0);
        chk("reset_cnt", 32'(BEAT_CNT), 32'd0);
        chk("reset_flags", {28'd0, BURST_ACTIVE, BURST_LAST, EARLY_TERM, SEQ_ERR}, 32'd0);
        HRESETn = 1'b1;
        cycle(2'b00, 32'h0, 3'd0, 3'd0, 1'b1);

        // INCR4 at 0x100, word beats.
        cycle(2'b10, 32'h100, 3'd2, 3'b011, 1'b1);
        chk("incr4_b1_cnt", 32'(BEAT_CNT), 32'd1);
        chk("incr4_b1_next", NEXT_ADDR, 32'h104);
        chk("incr4_b1_active", 32'(BURST_ACTIVE), 32'd1);
        cycle(2'b11, 32'h104, 3'd2, 3'b011, 1'b1);
        cycle(2'b11, 32'h108, 3'd2, 3'b011, 1'b1);
        chk("incr4_b3_cnt", 32'(BEAT_CNT), 32'd3);
        cycle(2'b11, 32'h10C, 3'd2, 3'b011, 1'b1);
        chk("incr4_b4_cnt", 32'(BEAT_CNT), 32'd4);
        chk("incr4_last", 32'(BURST_LAST), 32'd1);
        chk("incr4_active", 32'(BURST_ACTIVE), 32'd0);
        chk("incr4_err", 32'(SEQ_ERR), 32'd0);
        chk("incr4_next", NEXT_ADDR, 32'h110);
        cycle(2'b10, 32'h500, 3'd2, 3'b011, 1'b0);
        chk("stall_last", 32'(BURST_LAST), 32'd0);
        chk("stall_cnt", 32'(BEAT_CNT), 32'd4);
        chk("stall_next", NEXT_ADDR, 32'h110);

        // WRAP4 at 0x38.
        cycle(2'b10, 32'h38, 3'd2, 3'b010, 1'b1);
        chk("wrap4_n1", NEXT_ADDR, 32'h3C);
        cycle(2'b11, 32'h3C, 3'd2, 3'b010, 1'b1);
        chk("wrap4_n2", NEXT_ADDR, 32'h30);
        cycle(2'b11, 32'h30, 3'd2, 3'b010, 1'b1);
        chk("wrap4_n3", NEXT_ADDR, 32'h34);
        chk("wrap4_nolast", 32'(BURST_LAST), 32'd0);
        cycle(2'b11, 32'h34, 3'd2, 3'b010, 1'b1);
        chk("wrap4_last", 32'(BURST_LAST), 32'd1);

        // INCR8 at 0x0 with two BUSY cycles after beat 3.
        cycle(2'b10, 32'h0, 3'd2, 3'b101, 1'b1);
        cycle(2'b11, 32'h4, 3'd2, 3'b101, 1'b1);
        cycle(2'b11, 32'h8, 3'd2, 3'b101, 1'b1);
        cycle(2'b01, 32'hC, 3'd2, 3'b101, 1'b1);
        cycle(2'b01, 32'hC, 3'd2, 3'b101, 1'b1);
        chk("incr8_busy_cnt", 32'(BEAT_CNT), 32'd3);
        chk("incr8_busy_active", 32'(BURST_ACTIVE), 32'd1);
        chk("incr8_busy_next", NEXT_ADDR, 32'hC);
        for (int i = 3; i < 8; i++) cycle(2'b11, 32'(4 * i), 3'd2, 3'b101, 1'b1);
        chk("incr8_cnt", 32'(BEAT_CNT), 32'd8);
        chk("incr8_last", 32'(BURST_LAST), 32'd1);

        // WRAP8 cut short by NONSEQ after beat 5.
        cycle(2'b10, 32'h20, 3'd2, 3'b100, 1'b1);
        for (int i = 1; i < 5; i++) cycle(2'b11, 32'h20 + 32'(4 * i), 3'd2, 3'b100, 1'b1);
        chk("wrap8_cnt5", 32'(BEAT_CNT), 32'd5);
        cycle(2'b10, 32'h80, 3'd2, 3'b001, 1'b1);
        chk("wrap8_early", 32'(EARLY_TERM), 32'd1);
        chk("wrap8_newcnt", 32'(BEAT_CNT), 32'd1);
        chk("wrap8_newnext", NEXT_ADDR, 32'h84);
        cycle(2'b00, 32'h0, 3'd2, 3'b001, 1'b1);
        chk("incr_noearly", 32'(EARLY_TERM), 32'd0);
        chk("incr_closed", 32'(BURST_ACTIVE), 32'd0);

        // INCR16 with a wrong address, then reset during beat 6.
        cycle(2'b10, 32'h200, 3'd2, 3'b111, 1'b1);
        cycle(2'b11, 32'h204, 3'd2, 3'b111, 1'b1);
        cycle(2'b11, 32'h20C, 3'd2, 3'b111, 1'b1);
        chk("incr16_err", 32'(SEQ_ERR), 32'd1);
        chk("incr16_err_next", NEXT_ADDR, 32'h20C);
        cycle(2'b11, 32'h20C, 3'd2, 3'b111, 1'b1);
        chk("incr16_err_clear", 32'(SEQ_ERR), 32'd0);
        chk("incr16_cnt4", 32'(BEAT_CNT), 32'd4);
        cycle(2'b11, 32'h210, 3'd2, 3'b111, 1'b1);
        cycle(2'b11, 32'h214, 3'd2, 3'b111, 1'b1);
        chk("incr16_cnt6", 32'(BEAT_CNT), 32'd6);
        mid_reset(1'b1);
        cycle(2'b11, 32'h40, 3'd2, 3'b111, 1'b1);
        chk("post_rst_seq_err", 32'(SEQ_ERR), 32'd1);
        chk("post_rst_cnt", 32'(BEAT_CNT), 32'd0);

        // INCR at 0x3FC predicts across the 1KB line.
        cycle(2'b10, 32'h3FC, 3'd2, 3'b001, 1'b1);
        chk("kb_next", NEXT_ADDR, 32'h400);
`ifdef AHB_1KB_BOUNDARY_CHECK_EN
        chk("kb_err", 32'(SEQ_ERR), 32'd1);
`else
        chk("kb_err", 32'(SEQ_ERR), 32'd0);
`endif
        // Unbounded INCR saturates at 16 beats.
        for (int i = 1; i < 18; i++) cycle(2'b11, 32'h3FC + 32'(4 * i), 3'd2, 3'b001, 1'b1);
        chk("incr_sat", 32'(BEAT_CNT), 32'd16);
        cycle(2'b00, 32'h0, 3'd0, 3'd0, 1'b1);

        for (int n = 0; n < 300; n++) random_burst();
        cycle(2'b00, 32'h0, 3'd0, 3'd0, 1'b1);
        @(negedge HCLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
